// File: rtl/fetch_line_if.sv
// Arbiter and main system bus signals shared by the line fetch/writeback paths.
// The master side is the cache line engine; the slave side is the arbiter/bus.

`ifndef SYSBUS_READ
`define SYSBUS_READ 1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

interface fetch_line_if #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13
) ();
  logic                      abtr_reqcyc;
  logic                      abtr_grant;
  logic                      bus_busy;
  logic                      main_bus_reqcyc;
  logic                      main_bus_reqack;
  logic [BUS_DATA_WIDTH-1:0] main_bus_req;
  logic [BUS_TAG_WIDTH-1:0]  main_bus_reqtag;
  logic                      main_bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] main_bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  main_bus_resptag;
  logic                      main_bus_respack;

  modport master (
    output abtr_reqcyc,
    input  abtr_grant,
    output bus_busy,
    output main_bus_reqcyc,
    input  main_bus_reqack,
    output main_bus_req,
    output main_bus_reqtag,
    input  main_bus_respcyc,
    input  main_bus_resp,
    input  main_bus_resptag,
    output main_bus_respack
  );

  modport slave (
    input  abtr_reqcyc,
    output abtr_grant,
    input  bus_busy,
    input  main_bus_reqcyc,
    output main_bus_reqack,
    input  main_bus_req,
    input  main_bus_reqtag,
    output main_bus_respcyc,
    output main_bus_resp,
    output main_bus_resptag,
    input  main_bus_respack
  );
endinterface

// File: rtl/fetch_line.sv
// Cache line fetch: arbitrates for the main bus, issues one memory read for the
// line containing i_addr, gathers BEATS response beats and presents the line.

`ifndef SYSBUS_READ
`define SYSBUS_READ 1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module fetch_line #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned BEATS          = 8
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_enable,
  input  logic [BUS_DATA_WIDTH-1:0]       i_addr,
  fetch_line_if.master                    bus,
  output logic [BUS_DATA_WIDTH*BEATS-1:0] o_data,
  output logic                            o_ready
);

  localparam int unsigned CntW = $clog2(BEATS);
  localparam int unsigned OffW = $clog2(BUS_DATA_WIDTH / 8 * BEATS);
  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);
  localparam logic [BUS_TAG_WIDTH-1:0] ReqTag =
      BUS_TAG_WIDTH'((`SYSBUS_READ << 12) | (`SYSBUS_MEMORY << 8));

  typedef enum logic [2:0] {StIdle, StArb, StReq, StResp, StReady} state_e;

  state_e                           r_state;
  state_e                           w_state_next;
  logic [CntW-1:0]                  r_cnt;
  logic [BUS_DATA_WIDTH-1:0]        r_line_addr;
  logic [BUS_DATA_WIDTH*BEATS-1:0]  r_data;
  logic                             w_start;
  logic                             w_beat;
  logic                             w_req_done;

  assign o_data = r_data;

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and bus outputs; everything is idle unless a state drives it
  always_comb begin
    w_state_next         = r_state;
    w_start              = 1'b0;
    w_beat               = 1'b0;
    w_req_done           = 1'b0;
    o_ready              = 1'b0;
    bus.abtr_reqcyc      = 1'b0;
    bus.bus_busy         = 1'b0;
    bus.main_bus_reqcyc  = 1'b0;
    bus.main_bus_req     = '0;
    bus.main_bus_reqtag  = '0;
    bus.main_bus_respack = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_enable) begin
          w_start      = 1'b1;
          w_state_next = StArb;
        end
      end
      StArb: begin
        bus.abtr_reqcyc = 1'b1;
        if (bus.abtr_grant) w_state_next = StReq;
      end
      StReq: begin
        bus.bus_busy        = 1'b1;
        bus.main_bus_reqcyc = 1'b1;
        bus.main_bus_req    = r_line_addr;
        bus.main_bus_reqtag = ReqTag;
        if (bus.main_bus_reqack) begin
          w_req_done   = 1'b1;
          w_state_next = StResp;
        end
      end
      StResp: begin
        bus.bus_busy = 1'b1;
        // Only beats carrying our own tag belong to this line
        if (bus.main_bus_respcyc && (bus.main_bus_resptag == ReqTag)) begin
          bus.main_bus_respack = 1'b1;
          w_beat               = 1'b1;
          if (r_cnt == LastBeat) w_state_next = StReady;
        end
      end
      StReady: begin
        o_ready = 1'b1;
        if (i_enable) begin
          w_start      = 1'b1;
          w_state_next = StArb;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Line address latch, beat counter and line assembly
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_line_addr <= '0;
      r_cnt       <= '0;
      r_data      <= '0;
    end else begin
      if (w_start) r_line_addr <= {i_addr[BUS_DATA_WIDTH-1:OffW], {OffW{1'b0}}};
      if (w_req_done) begin
        r_cnt <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_beat) r_data[r_cnt*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus.main_bus_resp;
    end
  end

endmodule

// File: tb/tb_fetch_line.sv
// Directed bench for fetch_line: basic fetch, delays, foreign tags, async reset,
// ignored enable and restart from READY.

module tb_fetch_line;

  localparam logic [12:0]  Tag = 13'h1100;
  localparam logic [63:0]  A1  = 64'h1234_5678_9ABC_DEF7;
  localparam logic [63:0]  L1  = 64'h1234_5678_9ABC_DEC0;
  localparam logic [63:0]  A3  = 64'hFEDC_BA98_7654_323F;
  localparam logic [63:0]  L3  = 64'hFEDC_BA98_7654_3200;
  localparam logic [63:0]  A5  = 64'hAAAA_5555_0F0F_F0FF;
  localparam logic [63:0]  L5  = 64'hAAAA_5555_0F0F_F0C0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [63:0]  addr;
  logic [511:0] data;
  logic         ready;
  logic [511:0] exp1;
  logic [511:0] exp3;

  int checks = 0;
  int failures = 0;

  fetch_line_if u_bus ();

  fetch_line u_dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .i_enable(enable),
    .i_addr  (addr),
    .bus     (u_bus),
    .o_data  (data),
    .o_ready (ready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] cval(input int k);
    return 64'hC0DE_0000_0000_0000 | 64'(k);
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One accepted beat in RESP: respack must fire and the block must still own the bus
  task automatic beat(input logic [63:0] v);
    u_bus.main_bus_respcyc = 1'b1;
    u_bus.main_bus_resp    = v;
    u_bus.main_bus_resptag = Tag;
    #1;
    chk("beat_respack", u_bus.main_bus_respack, 1'b1);
    chk("beat_busy", u_bus.bus_busy, 1'b1);
    chk("beat_abtr", u_bus.abtr_reqcyc, 1'b0);
    chk("beat_ready_low", ready, 1'b0);
    tick();
    u_bus.main_bus_respcyc = 1'b0;
    u_bus.main_bus_resp    = 64'hDEAD_DEAD_DEAD_DEAD;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      exp1[64*k +: 64] = 64'(k);
      exp3[64*k +: 64] = cval(k);
    end
    rst_n = 1'b0; enable = 1'b0; addr = '0;
    u_bus.abtr_grant = 1'b0; u_bus.main_bus_reqack = 1'b0;
    u_bus.main_bus_respcyc = 1'b0; u_bus.main_bus_resp = '0; u_bus.main_bus_resptag = '0;
    tick(); tick();
    chk("rst_ready", ready, 1'b0);
    chk("rst_data", data, '0);
    chk("rst_abtr", u_bus.abtr_reqcyc, 1'b0);
    chk("rst_busy", u_bus.bus_busy, 1'b0);
    chk("rst_reqcyc", u_bus.main_bus_reqcyc, 1'b0);
    chk("rst_respack", u_bus.main_bus_respack, 1'b0);
    chk("rst_req", u_bus.main_bus_req, '0);
    chk("rst_reqtag", u_bus.main_bus_reqtag, '0);
    rst_n = 1'b1;
    tick();

    // 1: basic back-to-back fetch
    enable = 1'b1; addr = A1; u_bus.abtr_grant = 1'b1; u_bus.main_bus_reqack = 1'b1;
    tick();
    enable = 1'b0; #1;
    chk("s1_arb_abtr", u_bus.abtr_reqcyc, 1'b1);
    chk("s1_arb_busy", u_bus.bus_busy, 1'b0);
    tick(); #1;
    chk("s1_req_cyc", u_bus.main_bus_reqcyc, 1'b1);
    chk("s1_req_addr", u_bus.main_bus_req, L1);
    chk("s1_req_tag", u_bus.main_bus_reqtag, Tag);
    chk("s1_req_busy", u_bus.bus_busy, 1'b1);
    chk("s1_req_abtr", u_bus.abtr_reqcyc, 1'b0);
    tick(); #1;
    chk("s1_resp_reqcyc", u_bus.main_bus_reqcyc, 1'b0);
    chk("s1_resp_req", u_bus.main_bus_req, '0);
    chk("s1_resp_tag", u_bus.main_bus_reqtag, '0);
    for (int k = 0; k < 8; k++) beat(64'(k));
    #1;
    chk("s1_ready", ready, 1'b1);
    chk("s1_ready_busy", u_bus.bus_busy, 1'b0);
    chk("s1_data", data, exp1);
    chk("s1_data_lo", data[63:0], 64'd0);
    chk("s1_data_hi", data[511:448], 64'd7);
    u_bus.abtr_grant = 1'b0; u_bus.main_bus_reqack = 1'b0;
    tick(); #1;
    chk("s1_ready_hold", ready, 1'b1);
    chk("s1_data_hold", data, exp1);

    // 2: withheld grant, withheld reqack, gaps between beats
    enable = 1'b1; addr = A1;
    tick();
    enable = 1'b0; #1;
    chk("s2_ready_drop", ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("s2_wait_abtr", u_bus.abtr_reqcyc, 1'b1);
      chk("s2_wait_reqcyc", u_bus.main_bus_reqcyc, 1'b0);
      tick();
    end
    u_bus.abtr_grant = 1'b1;
    tick();
    u_bus.abtr_grant = 1'b0; #1;
    chk("s2_req_abtr", u_bus.abtr_reqcyc, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("s2_hold_cyc", u_bus.main_bus_reqcyc, 1'b1);
      chk("s2_hold_req", u_bus.main_bus_req, L1);
      chk("s2_hold_tag", u_bus.main_bus_reqtag, Tag);
      tick();
    end
    u_bus.main_bus_reqack = 1'b1;
    tick();
    u_bus.main_bus_reqack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < 2; g++) begin
        u_bus.main_bus_resptag = Tag; #1;
        chk("s2_gap_respack", u_bus.main_bus_respack, 1'b0);
        tick();
      end
      beat(64'(k));
    end
    #1;
    chk("s2_ready", ready, 1'b1);
    chk("s2_data", data, exp1);

    // 3: foreign-tag beat before beat 3
    enable = 1'b1; addr = A3; u_bus.abtr_grant = 1'b1; u_bus.main_bus_reqack = 1'b1;
    tick();
    enable = 1'b0;
    tick(); #1;
    chk("s3_req_addr", u_bus.main_bus_req, L3);
    tick();
    u_bus.abtr_grant = 1'b0; u_bus.main_bus_reqack = 1'b0;
    for (int k = 0; k < 3; k++) beat(cval(k));
    u_bus.main_bus_respcyc = 1'b1; u_bus.main_bus_resp = 64'hBAD0; u_bus.main_bus_resptag = '0;
    #1;
    chk("s3_foreign_respack", u_bus.main_bus_respack, 1'b0);
    tick();
    for (int k = 3; k < 8; k++) beat(cval(k));
    #1;
    chk("s3_ready", ready, 1'b1);
    chk("s3_beat3", data[255:192], cval(3));
    chk("s3_data", data, exp3);

    // 4: asynchronous reset after beat 4
    enable = 1'b1; addr = A1; u_bus.abtr_grant = 1'b1; u_bus.main_bus_reqack = 1'b1;
    tick();
    enable = 1'b0;
    tick(); tick();
    u_bus.abtr_grant = 1'b0; u_bus.main_bus_reqack = 1'b0;
    for (int k = 0; k < 5; k++) beat(64'(k));
    u_bus.main_bus_respcyc = 1'b1; u_bus.main_bus_resp = 64'd5; u_bus.main_bus_resptag = Tag;
    #1;
    rst_n = 1'b0;
    #1;
    chk("s4_abtr", u_bus.abtr_reqcyc, 1'b0);
    chk("s4_busy", u_bus.bus_busy, 1'b0);
    chk("s4_reqcyc", u_bus.main_bus_reqcyc, 1'b0);
    chk("s4_respack", u_bus.main_bus_respack, 1'b0);
    chk("s4_ready", ready, 1'b0);
    chk("s4_data", data, '0);
    tick();
    rst_n = 1'b1; u_bus.main_bus_respcyc = 1'b0;
    tick();

    // 5: fresh fetch with enable toggling in RESP, then restart from READY
    enable = 1'b1; addr = A3; u_bus.abtr_grant = 1'b1; u_bus.main_bus_reqack = 1'b1;
    tick();
    enable = 1'b0;
    tick(); #1;
    chk("s5_req_addr", u_bus.main_bus_req, L3);
    tick();
    u_bus.abtr_grant = 1'b0; u_bus.main_bus_reqack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      enable = (k % 2 == 0);
      beat(cval(k));
    end
    enable = 1'b0; #1;
    chk("s5_ready", ready, 1'b1);
    chk("s5_data", data, exp3);
    enable = 1'b1; addr = A5; #1;
    chk("s5_ready_before_edge", ready, 1'b1);
    tick();
    enable = 1'b0; #1;
    chk("s5_restart_ready", ready, 1'b0);
    chk("s5_restart_abtr", u_bus.abtr_reqcyc, 1'b1);
    u_bus.abtr_grant = 1'b1;
    tick();
    u_bus.abtr_grant = 1'b0; #1;
    chk("s5_new_req", u_bus.main_bus_req, L5);
    chk("s5_new_cyc", u_bus.main_bus_reqcyc, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
